// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for pipe_ctrl: stall vector patterns, exception codes, FSM states.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_FROM_IF  = 6'b000011;
  localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

  localparam logic [31:0] EXC_NONE         = 32'h00000000;
  localparam logic [31:0] EXC_INT          = 32'h00000001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h00000008;
  localparam logic [31:0] EXC_BREAK        = 32'h00000009;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000000a;
  localparam logic [31:0] EXC_OV           = 32'h0000000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000000e;

  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HOLDOFF = 2'd2
  } pipe_state_e;

  // Deepest stalling stage wins; it freezes itself and everything upstream.
  function automatic logic [5:0] stall_pattern(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_FROM_MEM;
    else if (req_ex) return STALL_FROM_EX;
    else if (req_id) return STALL_FROM_ID;
    else if (req_if) return STALL_FROM_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter (sat_counter) with synchronous clear.
module pipe_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception/ERET flush sequencing, stall-cycle counter.
// Optional stall watchdog enabled with `define PIPE_CTRL_WDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h00000020,
  parameter int          HOLDOFF_CYCLES = 3,
`ifdef PIPE_CTRL_WDOG_EN
  parameter int          WDOG_LIMIT     = 1024,
`endif
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
`ifdef PIPE_CTRL_WDOG_EN
  output logic             wdog_timeout,
`endif
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e       r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [31:0]       r_new_pc, w_new_pc_nxt;
  logic              w_accept;
  logic              w_flush;
  logic [5:0]        w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_new_pc   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_new_pc   <= w_new_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_new_pc_nxt = r_new_pc;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (excepttype_i != EXC_NONE) begin
          w_accept     = 1'b1;
          // Only ERET returns to EPC; every other code enters the common handler.
          w_new_pc_nxt = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          w_state_nxt  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_HOLDOFF;
        w_hold_nxt  = HOLD_W'(HOLDOFF_CYCLES);
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt <= HOLD_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign w_flush = (r_state == ST_FLUSH);
  assign w_stall = (w_flush || w_accept) ? STALL_NONE
                 : stall_pattern(stallreq_from_if, stallreq_from_id,
                                 stallreq_from_ex, stallreq_from_mem);

  assign stall  = w_stall;
  assign flush  = w_flush;
  assign new_pc = r_new_pc;

  pipe_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_stall[0]),
    .o_cnt (stall_cnt)
  );

`ifdef PIPE_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] w_wdog_cnt;
  logic              r_wdog_timeout;

  // Counts the current unbroken run of stalled cycles.
  pipe_ctrl_sat_counter #(.W(WDOG_W)) u_wdog_cnt (
    .clk   (clk),
    .i_clr (rst || (w_stall == STALL_NONE)),
    .i_inc (1'b1),
    .o_cnt (w_wdog_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_timeout <= 1'b0;
    end else if (w_wdog_cnt >= WDOG_W'(WDOG_LIMIT)) begin
      r_wdog_timeout <= 1'b1;
    end
  end

  assign wdog_timeout = r_wdog_timeout;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: stall priority, flush sequencing, holdoff, counters, reset.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] exc, epc;

  logic [5:0]  stall, s_stall;
  logic        flush, s_flush;
  logic [31:0] new_pc, s_new_pc;
  logic [31:0] stall_cnt;
  logic [2:0]  s_cnt;
`ifdef PIPE_CTRL_WDOG_EN
  logic        wdog, s_wdog;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
`ifdef PIPE_CTRL_WDOG_EN
    .wdog_timeout      (wdog),
`endif
    .stall_cnt         (stall_cnt)
  );

  pipe_ctrl #(.CNT_W(3)) dut_s (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .stall             (s_stall),
    .flush             (s_flush),
    .new_pc            (s_new_pc),
`ifdef PIPE_CTRL_WDOG_EN
    .wdog_timeout      (s_wdog),
`endif
    .stall_cnt         (s_cnt)
  );

  task automatic clear_inputs();
    req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
    exc = 32'h0; epc = 32'h0;
  endtask

  // Leaves the bench at the drive point (1 ns after a rising edge) with rst low.
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall got %b exp %b", stall, 6'b0); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    checks++; if (s_cnt !== 3'h0) begin errors++; $display("FAIL reset_small_cnt got %0d exp 0", s_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stall_priority();
    logic [3:0] reqs [6];
    logic [5:0] exps [6];
    reqs[0] = 4'b0010; exps[0] = 6'b000111; // {mem,ex,id,if}
    reqs[1] = 4'b0110; exps[1] = 6'b001111;
    reqs[2] = 4'b1111; exps[2] = 6'b011111;
    reqs[3] = 4'b0001; exps[3] = 6'b000011;
    reqs[4] = 4'b0000; exps[4] = 6'b000000;
    reqs[5] = 4'b1001; exps[5] = 6'b011111;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      {req_mem, req_ex, req_id, req_if} = reqs[i];
      @(negedge clk);
      checks++;
      if (stall !== exps[i]) begin
        errors++; $display("FAIL stall_prio[%0d] got %b exp %b", i, stall, exps[i]);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_single_exc();
    apply_reset();
    req_mem = 1'b1;
    exc = 32'h8;
    exp_pc_q.push_back(32'h20);
    @(negedge clk);
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL accept_stall got %b exp 0", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL accept_flush got %b exp 0", flush); end
    @(posedge clk); #1;
    exc = 32'h0;
    @(negedge clk);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL single_flush got %b exp 1", flush); end
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    if (exp_pc_q.size() == 0) begin
      errors++; $display("FAIL single_pc_queue got empty exp entry");
    end else begin
      exp_pc = exp_pc_q.pop_front();
      checks++; if (new_pc !== exp_pc) begin errors++; $display("FAIL single_new_pc got %h exp %h", new_pc, exp_pc); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL single_flush_end got %b exp 0", flush); end
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL holdoff_stall got %b exp %b", stall, 6'b011111); end
    checks++; if (new_pc !== 32'h20) begin errors++; $display("FAIL holdoff_pc_hold got %h exp %h", new_pc, 32'h20); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_exc_codes();
    logic [31:0] codes [8];
    codes[0] = 32'h1; codes[1] = 32'h9; codes[2] = 32'ha; codes[3] = 32'hc;
    codes[4] = 32'hd; codes[5] = 32'h4; codes[6] = 32'h80000000; codes[7] = 32'he;
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      epc = 32'h00400100;
      exc = codes[i];
      exp_pc_q.push_back((codes[i] == 32'he) ? 32'h00400100 : 32'h20);
      @(posedge clk); #1;
      exc = 32'h0;
      epc = 32'hdeadbeef;
      @(negedge clk);
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL code_flush[%h] got %b exp 1", codes[i], flush); end
      if (exp_pc_q.size() == 0) begin
        errors++; $display("FAIL code_pc_queue[%h] got empty exp entry", codes[i]);
      end else begin
        exp_pc = exp_pc_q.pop_front();
        checks++; if (new_pc !== exp_pc) begin errors++; $display("FAIL code_new_pc[%h] got %h exp %h", codes[i], new_pc, exp_pc); end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_holdoff();
    logic exp_flush;
    apply_reset();
    exc = 32'hc;
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 5) exp_pc_q.push_back(32'h20);
      exp_flush = (c == 1 || c == 6);
      @(negedge clk);
      checks++;
      if (flush !== exp_flush) begin
        errors++; $display("FAIL holdoff_flush[c%0d] got %b exp %b", c, flush, exp_flush);
      end
      if (flush === 1'b1) begin
        if (exp_pc_q.size() == 0) begin
          errors++; $display("FAIL holdoff_pc_queue[c%0d] got empty exp entry", c);
        end else begin
          exp_pc = exp_pc_q.pop_front();
          checks++; if (new_pc !== exp_pc) begin errors++; $display("FAIL holdoff_new_pc[c%0d] got %h exp %h", c, new_pc, exp_pc); end
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_counter();
    int lens [3];
    int exp_cnt;
    int exp_small;
    lens[0] = 7; lens[1] = 3; lens[2] = 5;
    exp_cnt = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      req_ex = 1'b1;
      repeat (lens[i]) @(posedge clk);
      #1;
      req_ex = 1'b0;
      exp_cnt += lens[i];
      exp_small = (exp_cnt > 7) ? 7 : exp_cnt;
      @(negedge clk);
      checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, stall_cnt, exp_cnt); end
      checks++; if (s_cnt !== 3'(exp_small)) begin errors++; $display("FAIL small_cnt_sat[%0d] got %0d exp %0d", i, s_cnt, exp_small); end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_flush();
    apply_reset();
    req_ex = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exc = 32'h8;
    exp_pc_q.push_back(32'h20);
    @(negedge clk);
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL exc_over_stall got %b exp 0", stall); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL pre_reset_cnt got %0d exp 3", stall_cnt); end
    @(posedge clk); #1;
    exc = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rif_flush got %b exp 1", flush); end
    if (exp_pc_q.size() == 0) begin
      errors++; $display("FAIL rif_pc_queue got empty exp entry");
    end else begin
      exp_pc = exp_pc_q.pop_front();
      checks++; if (new_pc !== exp_pc) begin errors++; $display("FAIL rif_new_pc got %h exp %h", new_pc, exp_pc); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_ex = 1'b0;
    exc = 32'h9;
    exp_pc_q.push_back(32'h20);
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL post_rst_flush got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL post_rst_new_pc got %h exp 0", new_pc); end
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL post_rst_cnt got %0d exp 0", stall_cnt); end
    @(posedge clk); #1;
    exc = 32'h0;
    @(negedge clk);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL post_rst_accept got %b exp 1", flush); end
    if (exp_pc_q.size() == 0) begin
      errors++; $display("FAIL post_rst_pc_queue got empty exp entry");
    end else begin
      exp_pc = exp_pc_q.pop_front();
      checks++; if (new_pc !== exp_pc) begin errors++; $display("FAIL post_rst_new_pc2 got %h exp %h", new_pc, exp_pc); end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish by 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_stall_priority();
    test_single_exc();
    test_exc_codes();
    test_holdoff();
    test_counter();
    test_reset_in_flush();
    checks++;
    if (exp_pc_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_pc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the six-stage MIPS core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the 6-bit stall vector consumed by every inter-stage register.
- Sequences exception and ERET flushes: registered flush pulse plus redirect PC, then a hold-off window before a new exception can be accepted.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
EXC_VECTOR, 32'h00000020, handler entry address for all non-ERET exceptions
HOLDOFF_CYCLES, 3, cycles after a flush during which new exceptions are ignored (1..15)
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stallreq_from_if  in  1  IF stage needs a stall (e.g. instruction fetch wait)
stallreq_from_id  in  1  ID stage needs a stall (load-use hazard)
stallreq_from_ex  in  1  EX stage needs a stall (multi-cycle div/madd)
stallreq_from_mem  in  1  MEM stage needs a stall (data bus wait)
excepttype_i  in  32  exception code from MEM; 0 means none
cp0_epc_i  in  32  current EPC from CP0, used for ERET
stall  out  6  stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
flush  out  1  one-cycle pipeline flush pulse
new_pc  out  32  redirect address, valid while flush=1
stall_cnt  out  CNT_W  cycles with stall[0]=1, saturating

Behaviour:
- Reset values: stall=0, flush=0, new_pc=0, stall_cnt=0, FSM=IDLE, holdoff counter=0.
- Stall vector is combinational and uses a fixed priority:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else if → 6'b000011
  - else 6'b000000
- Stall is forced to 6'b000000 whenever flush=1, or whenever a new exception is accepted in that cycle.
- FSM states: IDLE, FLUSH, HOLDOFF.
- IDLE:
  - If excepttype_i != 0, the exception is accepted. Next cycle, flush=1 and new_pc is registered from the exception code.
  - Code 32'h0000000e (ERET) → new_pc = cp0_epc_i, sampled in the accept cycle.
  - Codes 1, 8, 9, a, c, d → new_pc = EXC_VECTOR.
  - Any other nonzero code → new_pc = EXC_VECTOR.
  - Transition to FLUSH.
- FLUSH: lasts exactly 1 cycle (flush=1, new_pc held), then goes to HOLDOFF and loads the holdoff counter with HOLDOFF_CYCLES.
- HOLDOFF:
  - flush=0 and new_pc holds its last value.
  - excepttype_i is ignored, since squashed bubbles may still carry stale codes.
  - The counter decrements each cycle; at 1 the FSM returns to IDLE.
  - Stall requests are honoured normally.
- Latency from exception accept to flush is exactly 1 cycle. Back-to-back accepted exceptions are at least HOLDOFF_CYCLES+2 cycles apart.
- stall_cnt: increments when stall[0]=1, based on the post-masking vector. It saturates at all-ones and never wraps.
- Simultaneous exception and stall request in IDLE: the exception wins and stall reads 0 that cycle.
- Reset mid-FLUSH or mid-HOLDOFF: everything returns to reset values on the next edge, with no residual flush pulse.

Optional Feature:
Macro PIPE_CTRL_WDOG_EN adds a stall watchdog.
- With the macro:
  - Parameter WDOG_LIMIT (default 1024) and output wdog_timeout (1 bit) are added.
  - An internal counter counts consecutive cycles with stall != 0 and clears on any cycle with stall == 0.
  - When the counter reaches WDOG_LIMIT, wdog_timeout is set. It is sticky until rst.
  - The watchdog has no effect on stall or flush.
- Without the macro: neither the port nor the logic exists.

Decomposition:
- Shared package / instruction.v defines:
  - the stall vector patterns (STALL_NONE, STALL_FROM_IF, _ID, _EX, _MEM)
  - the exception code constants (EXC_INT, EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV, EXC_ERET)
  - the FSM state encodings
- One sub-module, sat_counter (width-parameterised saturating incrementer with synchronous clear), used for stall_cnt and the watchdog counter.

Test Plan:
- Requests: id=1 only, then ex=1 together with id=1, then mem=1 together with all others → stall = 6'b000111, then 6'b001111, then 6'b011111, each in the same cycle as the request.
- Single exception: excepttype_i=32'h8 for 1 cycle in IDLE → next cycle flush=1 and new_pc=32'h20 for exactly 1 cycle; stall=0 in the accept cycle and the flush cycle.
- ERET: cp0_epc_i=32'h00400100, excepttype_i=32'he → flush=1 and new_pc=32'h00400100 one cycle later.
- Holdoff: excepttype_i held at 32'hc for 10 cycles with HOLDOFF_CYCLES=3 → flush pulses at cycle 1 and cycle 6, nowhere else.
- Counter: stallreq_from_ex=1 for 7 cycles → stall_cnt=7. With CNT_W=3 and 10 stall cycles → stall_cnt=7, held with no wrap.
- Reset during FLUSH: assert rst in the flush cycle → next cycle flush=0, new_pc=0, stall_cnt=0, FSM=IDLE; a new exception is accepted immediately after reset is released.
